// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access, data first.
// Build option MEM_ARB_TIMEOUT_EN adds a mem_ready watchdog that completes with zero data and sets a sticky err.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                err
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic                mem_req_r, mem_req_nxt_s;
  logic                mem_we_r, mem_we_nxt_s;
  logic [BE_W-1:0]     mem_be_r, mem_be_nxt_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_nxt_s;
  logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_nxt_s;
  logic                if_ack_r, if_ack_nxt_s;
  logic                d_ack_r, d_ack_nxt_s;
  logic [DATA_W-1:0]   if_rdata_r, if_rdata_nxt_s;
  logic [DATA_W-1:0]   d_rdata_r, d_rdata_nxt_s;
  logic                d_elig_s, if_elig_s;
  logic                busy_s, complete_s, expire_s, done_s;

  // A requester is deaf in its own ack cycle so a still-held req cannot re-grant.
  assign d_elig_s   = d_req && !d_ack_r;
  assign if_elig_s  = if_req && !if_ack_r;
  assign busy_s     = (state_r != IDLE);
  assign complete_s = busy_s && mem_req_r && mem_ready;
  // Grant state with mem_req already dropped is the one-cycle wind-down before the ack.
  assign done_s     = busy_s && !mem_req_r;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             err_r;

  // This stall cycle takes the counter to TIMEOUT; a same-cycle mem_ready still wins.
  assign expire_s = busy_s && mem_req_r && !mem_ready && (cnt_r == CNT_W'(TIMEOUT - 1));

  // Stall counter: cleared while idle, counts grant cycles without mem_ready.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (!busy_s) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (mem_req_r && !mem_ready) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Stall counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
      err_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      err_r <= err_r | expire_s;
    end
  end

  assign err = err_r;
`else
  localparam int unused_timeout_s = TIMEOUT;
  assign expire_s = 1'b0;
  assign err      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: fixed data-first priority from IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (d_elig_s) begin
          state_nxt_s = GNT_D;
        end else if (if_elig_s) begin
          state_nxt_s = GNT_IF;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_IF, GNT_D: begin
        if (done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output logic: next values of every registered output.
  always_comb begin
    mem_req_nxt_s   = mem_req_r;
    mem_we_nxt_s    = mem_we_r;
    mem_be_nxt_s    = mem_be_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    if_rdata_nxt_s  = if_rdata_r;
    d_rdata_nxt_s   = d_rdata_r;
    if_ack_nxt_s    = 1'b0;
    d_ack_nxt_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (d_elig_s) begin
          mem_req_nxt_s   = 1'b1;
          mem_we_nxt_s    = d_we;
          mem_be_nxt_s    = d_be;
          mem_addr_nxt_s  = d_addr;
          mem_wdata_nxt_s = d_wdata;
        end else if (if_elig_s) begin
          mem_req_nxt_s   = 1'b1;
          mem_we_nxt_s    = 1'b0;
          mem_be_nxt_s    = {BE_W{1'b1}};
          mem_addr_nxt_s  = if_addr;
        end else begin
          mem_req_nxt_s   = 1'b0;
        end
      end
      GNT_IF, GNT_D: begin
        if (complete_s) begin
          mem_req_nxt_s = 1'b0;
          if (state_r == GNT_IF) begin
            if_rdata_nxt_s = mem_rdata;
          end else if (!mem_we_r) begin
            d_rdata_nxt_s = mem_rdata;
          end else begin
            d_rdata_nxt_s = d_rdata_r;
          end
        end else if (expire_s) begin
          mem_req_nxt_s = 1'b0;
          if (state_r == GNT_IF) begin
            if_rdata_nxt_s = {DATA_W{1'b0}};
          end else begin
            d_rdata_nxt_s = {DATA_W{1'b0}};
          end
        end else if (done_s) begin
          if_ack_nxt_s = (state_r == GNT_IF);
          d_ack_nxt_s  = (state_r == GNT_D);
        end else begin
          mem_req_nxt_s = mem_req_r;
        end
      end
      default: mem_req_nxt_s = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= {BE_W{1'b0}};
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      if_rdata_r  <= {DATA_W{1'b0}};
      d_rdata_r   <= {DATA_W{1'b0}};
      if_ack_r    <= 1'b0;
      d_ack_r     <= 1'b0;
    end else begin
      mem_req_r   <= mem_req_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_be_r    <= mem_be_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      if_rdata_r  <= if_rdata_nxt_s;
      d_rdata_r   <= d_rdata_nxt_s;
      if_ack_r    <= if_ack_nxt_s;
      d_ack_r     <= d_ack_nxt_s;
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_be    = mem_be_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign if_ack    = if_ack_r;
  assign d_ack     = d_ack_r;
  assign if_rdata  = if_rdata_r;
  assign d_rdata   = d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected acks, a monitor pops them.
// Build with MEM_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT=8).
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst;
  logic if_req, if_ack, d_req, d_we, d_ack, mem_req, mem_we, mem_ready, err;
  logic [ADDR_W-1:0] if_addr, d_addr, mem_addr;
  logic [DATA_W-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [3:0] d_be, mem_be;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_if;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int grants = 0;
  int last_if_ack = -1;
  int last_d_ack = -1;
  int last_ready = -1;
  logic prev_req = 1'b0;
  int mem_lat = 0;
  bit mem_en = 1'b1;
  int mem_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_for(input logic [31:0] a);
    case (a)
      32'h0000_0010: rd_for = 32'h0050_0093;
      32'h0000_0014: rd_for = 32'h00A0_0113;
      32'h0000_0200: rd_for = 32'h1111_2222;
      default:       rd_for = a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit is_if, input logic [31:0] d);
    exp_t e;
    e.is_if = is_if;
    e.rdata = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input bit want_if, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(want_if ? if_ack : d_ack) && n < 60);
    checks++;
    if (!(want_if ? if_ack : d_ack)) begin
      errors++;
      $display("FAIL %s: no ack within 60 cycles", nm);
    end
  endtask

  // Zero-wait fetch: ack is expected three cycles after the request appears.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input string nm);
    int r;
    r = cyc;
    if_addr = a;
    if_req = 1'b1;
    push_exp(1'b1, d);
    wait_ack(1'b1, nm);
    chk(nm, last_if_ack, r + 3);
    tick(1);
    if_req = 1'b0;
  endtask

  // Memory model: answers after mem_lat cycles of mem_req, or never when mem_en is low.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_en) begin
        if (mem_cnt >= mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = rd_for(mem_addr);
          last_ready = cyc;
        end else begin
          mem_ready = 1'b0;
          mem_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        mem_cnt = 0;
      end
    end
  end

  // Monitor: counts grants and checks every ack against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && prev_req !== 1'b1) grants++;
      prev_req = mem_req;
      if (if_ack === 1'b1 || d_ack === 1'b1) begin
        if (if_ack === 1'b1) last_if_ack = cyc;
        if (d_ack === 1'b1) last_d_ack = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: if_ack=%0b d_ack=%0b at cycle %0d", if_ack, d_ack, cyc);
        end else begin
          e = exp_q.pop_front();
          if ((if_ack === 1'b1) != e.is_if || (if_ack === 1'b1 && d_ack === 1'b1)) begin
            errors++;
            $display("FAIL ack_port: got if_ack=%0b d_ack=%0b expected is_if=%0b", if_ack, d_ack, e.is_if);
          end
          chk(e.is_if ? "if_rdata" : "d_rdata", e.is_if ? if_rdata : d_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, g0;
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    tick(3);
    chk("rst_ctrl", {28'h0, if_ack, d_ack, mem_req, mem_we}, 32'h0);
    chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", if_rdata | d_rdata, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    rst = 1'b0;
    tick(1);

    // Single zero-wait fetch.
    mem_lat = 0;
    r = cyc;
    if_addr = 32'h10; if_req = 1'b1;
    push_exp(1'b1, 32'h0050_0093);
    tick(1);
    chk("fetch_gnt_lat", {31'h0, mem_req}, 32'h1);
    chk("fetch_we", {31'h0, mem_we}, 32'h0);
    chk("fetch_be", {28'h0, mem_be}, 32'hF);
    chk("fetch_addr", mem_addr, 32'h10);
    wait_ack(1'b1, "fetch0");
    chk("fetch_ack_lat", last_if_ack, r + 3);
    tick(1);
    if_req = 1'b0;
    chk("fetch_rdata_hold", if_rdata, 32'h0050_0093);

    // Reset lands in GNT_D while mem_ready is high: no ack, everything cleared.
    tick(1);
    mem_lat = 3;
    r = cyc;
    d_we = 1'b0; d_be = 4'hF; d_addr = 32'h300; d_req = 1'b1;
    tick(4);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready_overlap", {31'h0, mem_ready}, 32'h1);
    @(posedge clk); #1;
    d_req = 1'b0;
    rst = 1'b0;
    chk("rst_mid_ctrl", {28'h0, if_ack, d_ack, mem_req, mem_we}, 32'h0);
    chk("rst_mid_addr", mem_addr, 32'h0);
    chk("rst_mid_if_rdata", if_rdata, 32'h0);
    tick(2);
    chk("rst_mid_no_dack", last_d_ack, 32'hFFFF_FFFF);
    mem_lat = 0;
    do_fetch(32'h14, 32'h00A0_0113, "fetch_after_rst");

    // Simultaneous store and fetch: data first, fetch granted right after d_ack.
    tick(1);
    g0 = grants;
    r = cyc;
    d_we = 1'b1; d_be = 4'h3; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    if_addr = 32'h18; if_req = 1'b1;
    push_exp(1'b0, 32'h0);
    push_exp(1'b1, 32'h5A5A_5A42);
    tick(1);
    chk("sim_d_addr", mem_addr, 32'h200);
    chk("sim_d_be", {28'h0, mem_be}, 32'h3);
    chk("sim_d_we", {31'h0, mem_we}, 32'h1);
    chk("sim_d_wdata", mem_wdata, 32'hDEAD_BEEF);
    wait_ack(1'b0, "sim_d");
    chk("sim_d_ack_lat", last_d_ack, r + 3);
    tick(1);
    d_req = 1'b0;
    chk("sim_if_req", {31'h0, mem_req}, 32'h1);
    chk("sim_if_addr", mem_addr, 32'h18);
    chk("sim_if_be_we", {27'h0, mem_be, mem_we}, 32'h1E);
    wait_ack(1'b1, "sim_if");
    chk("sim_if_ack_lat", last_if_ack, r + 6);
    tick(1);
    if_req = 1'b0;
    tick(2);
    chk("sim_grants", grants - g0, 32'd2);

    // Load with 5 wait states; requester address wanders during the wait.
    mem_lat = 5;
    r = cyc;
    d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200; d_req = 1'b1;
    push_exp(1'b0, 32'h1111_2222);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      d_addr = 32'h0000_0F00 + i;
      tick(1);
      chk("wait_addr_frozen", mem_addr, 32'h200);
    end
    wait_ack(1'b0, "wait_d");
    chk("wait_ready_lat", last_ready, r + 6);
    // mem_ready is sampled at the edge closing its cycle; the ack follows one edge later.
    chk("wait_ack_lat", last_d_ack, last_ready + 2);
    tick(1);
    d_req = 1'b0;
    d_addr = 32'h200;

    // Fetch keeps if_req high through its ack: exactly one more fetch.
    mem_lat = 0;
    tick(1);
    g0 = grants;
    r = cyc;
    if_addr = 32'h20; if_req = 1'b1;
    push_exp(1'b1, 32'h5A5A_5A7A);
    push_exp(1'b1, 32'h5A5A_5A7A);
    wait_ack(1'b1, "held1");
    chk("held_ack1_lat", last_if_ack, r + 3);
    tick(1);
    chk("held_no_regrant", {31'h0, mem_req}, 32'h0);
    tick(1);
    chk("held_regrant", {31'h0, mem_req}, 32'h1);
    wait_ack(1'b1, "held2");
    chk("held_ack2_lat", last_if_ack, r + 7);
    tick(1);
    if_req = 1'b0;
    tick(3);
    chk("held_grants", grants - g0, 32'd2);

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: 8 stall cycles, one wind-down cycle, then d_ack with zero data.
    mem_en = 1'b0;
    r = cyc;
    d_we = 1'b0; d_addr = 32'h40; d_req = 1'b1;
    push_exp(1'b0, 32'h0);
    wait_ack(1'b0, "tmo_d");
    chk("tmo_ack_lat", last_d_ack, r + 10);
    chk("tmo_err", {31'h0, err}, 32'h1);
    tick(1);
    d_req = 1'b0;
    mem_en = 1'b1;
    do_fetch(32'h10, 32'h0050_0093, "tmo_next_fetch");
    chk("tmo_err_sticky", {31'h0, err}, 32'h1);
`else
    chk("err_tied_low", {31'h0, err}, 32'h0);
`endif

    tick(2);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
